// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states and instruction-field helpers for the multicycle datapath.
// Instruction layout, MSB first: opcode[3] | rd | rs | low field (rt or sign-extended imm).
package cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_SW   = 3'b110;
  localparam logic [2:0] OP_BEQ  = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB
  } state_t;

  function automatic int imm_width(input int data_w, input int reg_aw);
    return data_w - 3 - 2 * reg_aw;
  endfunction

  // Fields are pulled through a 64-bit window so any instruction width up to 64 fits.
  function automatic logic [63:0] field_bits(input logic [63:0] word, input int lsb,
                                             input int width);
    logic [63:0] shifted;
    shifted = (lsb >= 0) ? (word >> lsb) : (word << (-lsb));
    return shifted & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic [63:0] opcode_of(input logic [63:0] ir, input int data_w);
    return field_bits(ir, data_w - 3, 3);
  endfunction

  function automatic logic [63:0] rd_of(input logic [63:0] ir, input int data_w,
                                        input int reg_aw);
    return field_bits(ir, data_w - 3 - reg_aw, reg_aw);
  endfunction

  function automatic logic [63:0] rs_of(input logic [63:0] ir, input int data_w,
                                        input int reg_aw);
    return field_bits(ir, data_w - 3 - 2 * reg_aw, reg_aw);
  endfunction

  // rt sits in the top bits of the low field; any bits below it are don't-care.
  function automatic logic [63:0] rt_of(input logic [63:0] ir, input int data_w,
                                        input int reg_aw);
    return field_bits(ir, imm_width(data_w, reg_aw) - reg_aw, reg_aw);
  endfunction

  function automatic logic [63:0] imm_of(input logic [63:0] ir, input int data_w,
                                         input int reg_aw);
    return field_bits(ir, 0, imm_width(data_w, reg_aw));
  endfunction

endpackage

// File: rtl/cpu_reg_file.sv
// Register file: two combinational read ports, a debug read port and one synchronous write.
// r0 is hard-wired to zero; writes addressed to it are discarded.
module cpu_reg_file #(
  parameter int DATA_W = 13,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [REG_AW-1:0] dbg_raddr_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o    = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o    = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
  assign dbg_rdata_o = (dbg_raddr_i == '0) ? '0 : regs_q[dbg_raddr_i];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle CPU: FETCH/DECODE/EXECUTE/MEM/WB over a req/done memory handshake.
// Memory-side outputs decode directly from registered state, so they hold steady across wait states.
module multicycle_datapath
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = 13,
  parameter int                ADDR_W   = 13,
  parameter int                REG_AW   = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              beq_taken,
  output logic              write_flag,
  output logic              retire,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int IMM_W = imm_width(DATA_W, REG_AW);

  if (IMM_W < 1) begin : g_bad_imm
    $fatal(1, "multicycle_datapath: DATA_W leaves no room for an immediate field");
  end
  if (ADDR_W > DATA_W) begin : g_bad_addr
    $fatal(1, "multicycle_datapath: ADDR_W must not exceed DATA_W");
  end

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q, a_q, b_q, aluOut_q, mdr_q;

  logic [2:0]        opcode;
  logic [REG_AW-1:0] rdAddr, rsAddr, rtAddr;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] immExt;

  assign opcode = 3'(opcode_of(64'(ir_q), DATA_W));
  assign rdAddr = REG_AW'(rd_of(64'(ir_q), DATA_W, REG_AW));
  assign rsAddr = REG_AW'(rs_of(64'(ir_q), DATA_W, REG_AW));
  assign rtAddr = REG_AW'(rt_of(64'(ir_q), DATA_W, REG_AW));
  assign imm    = IMM_W'(imm_of(64'(ir_q), DATA_W, REG_AW));
  assign immExt = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};

  logic              isRtype, branchTaken, regWe;
  logic [REG_AW-1:0] raddr2;
  logic [DATA_W-1:0] rdata1, rdata2, wbData, alu_d;
  state_t            boundary_d;

  // Second read port feeds B: rt for R-type, rd for SW store data and BEQ compare.
  assign isRtype     = ~opcode[2];
  assign raddr2      = isRtype ? rtAddr : rdAddr;
  assign branchTaken = (opcode == OP_BEQ) && (a_q == b_q);
  assign regWe       = (state_q == WB);
  assign wbData      = (opcode == OP_LW) ? mdr_q : aluOut_q;
  assign boundary_d  = run ? FETCH : IDLE;

  cpu_reg_file #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_reg_file (
    .clk        (clk),
    .reset      (reset),
    .raddr1_i   (rsAddr),
    .rdata1_o   (rdata1),
    .raddr2_i   (raddr2),
    .rdata2_o   (rdata2),
    .dbg_raddr_i(dbg_raddr),
    .dbg_rdata_o(dbg_rdata),
    .we_i       (regWe),
    .waddr_i    (rdAddr),
    .wdata_i    (wbData)
  );

  always_comb begin
    alu_d = a_q + immExt;
    case (opcode)
      OP_ADD:  alu_d = a_q + b_q;
      OP_SUB:  alu_d = a_q - b_q;
      OP_AND:  alu_d = a_q & b_q;
      OP_OR:   alu_d = a_q | b_q;
      default: alu_d = a_q + immExt;
    endcase
  end

  // pc is bumped in DECODE, so a taken branch only needs to add the offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluOut_q <= '0;
      mdr_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) state_q <= FETCH;
        end
        FETCH: begin
          if (mem_done) begin
            ir_q    <= mem_rdata;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          a_q     <= rdata1;
          b_q     <= rdata2;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= EXECUTE;
        end
        EXECUTE: begin
          aluOut_q <= alu_d;
          if (opcode == OP_BEQ) begin
            if (branchTaken) pc_q <= pc_q + immExt[ADDR_W-1:0];
            state_q <= boundary_d;
          end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
            state_q <= MEM;
          end else begin
            state_q <= WB;
          end
        end
        MEM: begin
          if (mem_done) begin
            if (opcode == OP_SW) begin
              state_q <= boundary_d;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= WB;
            end
          end
        end
        WB: begin
          state_q <= boundary_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = (state_q == FETCH) || (state_q == MEM);
  assign mem_we    = (state_q == MEM) && (opcode == OP_SW);
  assign mem_addr  = (state_q == FETCH) ? pc_q :
                     (state_q == MEM)   ? aluOut_q[ADDR_W-1:0] : '0;
  assign mem_wdata = (state_q == MEM) ? b_q : '0;

  assign pc         = pc_q;
  assign busy       = (state_q != IDLE);
  assign beq_taken  = (state_q == EXECUTE) && branchTaken;
  assign write_flag = regWe && (rdAddr != '0);
  assign retire     = (state_q == WB) ||
                      ((state_q == EXECUTE) && (opcode == OP_BEQ)) ||
                      ((state_q == MEM) && mem_done && (opcode == OP_SW));

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a small program runs from a wait-state memory model
// and each instruction's timing, pulses and register results are compared to hand-computed values.
module tb_multicycle_datapath;

  logic        clk;
  logic        reset;
  logic        run;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [12:0] mem_wdata;
  logic [12:0] mem_rdata;
  logic        mem_done;
  logic [12:0] pc;
  logic        busy;
  logic        beq_taken;
  logic        write_flag;
  logic        retire;
  logic [2:0]  dbg_raddr;
  logic [12:0] dbg_rdata;

  int tests = 0;
  int failures = 0;

  logic [12:0] memArr [32];
  int          waitCfg = 0;
  int          waitCnt = 0;
  logic        stValid = 1'b0;
  logic [12:0] stAddr = '0;
  logic [12:0] stData = '0;

  int          cycles, wfCnt, wfAt, btCnt, reqCnt;
  logic        addrMoved;
  logic [12:0] firstAddr;
  logic [12:0] regOr;

  multicycle_datapath dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .pc        (pc),
    .busy      (busy),
    .beq_taken (beq_taken),
    .write_flag(write_flag),
    .retire    (retire),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory answers after waitCfg wait cycles; the last store shadows the array so LW sees it.
  assign mem_done  = mem_req && (waitCnt >= waitCfg);
  assign mem_rdata = mem_done ? ((stValid && (mem_addr == stAddr)) ? stData
                                                                   : memArr[mem_addr[4:0]])
                              : 13'h1ABC;

  always @(posedge clk) begin
    if (reset) begin
      waitCnt <= 0;
      stValid <= 1'b0;
    end else begin
      waitCnt <= (mem_req && !mem_done) ? waitCnt + 1 : 0;
      if (mem_req && mem_done && mem_we) begin
        stValid <= 1'b1;
        stAddr  <= mem_addr;
        stData  <= mem_wdata;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReg(input logic [2:0] idx, input logic [12:0] expected,
                          input string tag);
    dbg_raddr = idx;
    #1;
    checkOutput(tag, 32'(dbg_rdata), 32'(expected));
  endtask

  // Steps from the current negedge until retire is seen, tallying pulses and request cycles.
  task automatic applyStimulus();
    int  n;
    logic seen;
    n = 0; seen = 1'b0;
    wfCnt = 0; wfAt = 0; btCnt = 0; reqCnt = 0; addrMoved = 1'b0; firstAddr = '0;
    while (!seen && n < 40) begin
      n++;
      if (write_flag) begin
        wfCnt++;
        wfAt = n;
      end
      if (beq_taken) btCnt++;
      if (mem_req) begin
        if (reqCnt == 0) firstAddr = mem_addr;
        else if (mem_addr != firstAddr) addrMoved = 1'b1;
        reqCnt++;
      end
      if (retire) seen = 1'b1;
      else @(negedge clk);
    end
    cycles = n;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) memArr[i] = '0;
    memArr[0]  = 13'h1085;   // ADDI r1,r0,5
    memArr[1]  = 13'h110F;   // ADDI r2,r0,-1
    memArr[2]  = 13'h0194;   // ADD  r3,r1,r2
    memArr[3]  = 13'h0602;   // SUB  r4,r0,r1
    memArr[4]  = 13'h1883;   // SW   r1,[r0+3]
    memArr[5]  = 13'h1683;   // LW   r5,[r0+3]
    memArr[6]  = 13'h1007;   // ADDI r0,r0,7
    memArr[7]  = 13'h1C02;   // BEQ  r0,r0,+2 -> 10
    memArr[9]  = 13'h1C01;   // BEQ  r0,r0,+1 -> 11
    memArr[10] = 13'h1C9E;   // BEQ  r1,r1,-2 -> 9
    memArr[11] = 13'h1C83;   // BEQ  r1,r0,+3 (not taken)
    memArr[12] = 13'h0312;   // ADD  r6,r1,r1

    reset = 1'b1; run = 1'b0; dbg_raddr = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset pc", 32'(pc), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset pulses", 32'({retire, write_flag, beq_taken}), 32'd0);

    reset = 1'b0; run = 1'b1;
    @(negedge clk);
    checkOutput("fetch0 req", 32'({mem_req, mem_we}), 32'b10);
    checkOutput("fetch0 addr", 32'(mem_addr), 32'd0);
    checkOutput("fetch0 busy", 32'(busy), 32'd1);
    applyStimulus();
    checkOutput("addi r1 cycles", 32'(cycles), 32'd4);
    checkOutput("addi r1 wf cycle", 32'(wfAt), 32'd4);
    checkOutput("addi r1 wf count", 32'(wfCnt), 32'd1);
    @(negedge clk);
    checkOutput("pc after addi", 32'(pc), 32'd1);
    checkOutput("no second retire", 32'(retire), 32'd0);
    checkReg(3'd1, 13'd5, "r1");

    applyStimulus();
    @(negedge clk);
    applyStimulus();
    checkOutput("add cycles", 32'(cycles), 32'd4);
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    checkReg(3'd2, 13'h1FFF, "r2");
    checkReg(3'd3, 13'd4, "r3");
    checkReg(3'd4, 13'h1FFB, "r4");

    applyStimulus();
    checkOutput("sw cycles", 32'(cycles), 32'd4);
    checkOutput("sw mem_we", 32'(mem_we), 32'd1);
    checkOutput("sw mem_addr", 32'(mem_addr), 32'd3);
    checkOutput("sw mem_wdata", 32'(mem_wdata), 32'd5);
    checkOutput("sw no write_flag", 32'(wfCnt), 32'd0);

    @(negedge clk);
    @(negedge clk);
    waitCfg = 3;
    applyStimulus();
    checkOutput("lw total cycles", 32'(cycles + 1), 32'd8);
    checkOutput("lw req cycles", 32'(reqCnt), 32'd4);
    checkOutput("lw addr", 32'(firstAddr), 32'd3);
    checkOutput("lw addr stable", 32'(addrMoved), 32'd0);
    checkOutput("lw write_flag", 32'(wfCnt), 32'd1);
    waitCfg = 0;
    @(negedge clk);
    checkReg(3'd5, 13'd5, "r5");

    applyStimulus();
    checkOutput("addi r0 cycles", 32'(cycles), 32'd4);
    checkOutput("addi r0 no wf", 32'(wfCnt), 32'd0);
    @(negedge clk);
    checkReg(3'd0, 13'd0, "r0");

    applyStimulus();
    checkOutput("beq fwd cycles", 32'(cycles), 32'd3);
    checkOutput("beq fwd taken", 32'(btCnt), 32'd1);
    @(negedge clk);
    checkOutput("pc at 10", 32'(pc), 32'd10);
    applyStimulus();
    checkOutput("beq back taken", 32'(btCnt), 32'd1);
    @(negedge clk);
    checkOutput("pc after back", 32'(pc), 32'd9);
    applyStimulus();
    @(negedge clk);
    checkOutput("pc at 11", 32'(pc), 32'd11);
    applyStimulus();
    checkOutput("beq not taken", 32'(btCnt), 32'd0);
    @(negedge clk);
    checkOutput("pc after not taken", 32'(pc), 32'd12);

    @(negedge clk);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    checkOutput("halt wb retire", 32'({retire, write_flag}), 32'b11);
    @(negedge clk);
    checkOutput("halt busy", 32'(busy), 32'd0);
    checkOutput("halt mem_req", 32'(mem_req), 32'd0);
    checkReg(3'd6, 13'd10, "r6");
    repeat (2) @(negedge clk);
    checkOutput("idle holds", 32'({busy, mem_req}), 32'd0);
    checkOutput("idle pc", 32'(pc), 32'd13);

    waitCfg = 100; run = 1'b1;
    @(negedge clk);
    checkOutput("wait fetch req", 32'(mem_req), 32'd1);
    checkOutput("wait fetch addr", 32'(mem_addr), 32'd13);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("mid reset pc", 32'(pc), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    regOr = '0;
    for (int r = 1; r < 8; r++) begin
      dbg_raddr = 3'(r);
      #1;
      regOr = regOr | dbg_rdata;
    end
    checkOutput("mid reset regs", 32'(regOr), 32'd0);
    reset = 1'b0; run = 1'b0; waitCfg = 0;
    @(negedge clk);
    checkOutput("post reset idle", 32'({busy, mem_req}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle CPU datapath and control FSM: fetch, decode, execute, memory and writeback, with an internal register file and ALU.
- Talks to the shared instruction/data memory over a req/done handshake, so memory latency can vary.
- Supersedes the fixed 13-bit datapath: data, address and register widths are generic, and it adds run/halt control and wait-state tolerance.

Parameters:
- DATA_W, 13, data and instruction width.
- ADDR_W, 13, memory address and PC width (ADDR_W <= DATA_W).
- REG_AW, 3, register address width; 2**REG_AW registers.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; 1 = execute, 0 = halt at next instruction boundary.
- mem_req  out  1  memory request, held until mem_done.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  memory address; stable while mem_req.
- mem_wdata  out  DATA_W  store data; stable while mem_req.
- mem_rdata  in  DATA_W  read data; valid in the mem_done cycle.
- mem_done  in  1  completes the request in the same cycle; ignored while mem_req=0.
- pc  out  ADDR_W  current PC.
- busy  out  1  FSM not in IDLE.
- beq_taken  out  1  1-cycle pulse when a branch is taken.
- write_flag  out  1  1-cycle pulse when a register is written.
- retire  out  1  1-cycle pulse on the last cycle of each instruction.
- dbg_raddr  in  REG_AW  debug register read address.
- dbg_rdata  out  DATA_W  combinational read of register dbg_raddr.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on port reset.
- Reset values:
  - state = IDLE, pc = RESET_PC, all registers = 0, IR/A/B/ALUOut/MDR = 0.
  - All outputs 0 (pc = RESET_PC).
  - Reset mid-request: mem_req = 0 the next cycle; any late mem_done is ignored.
- Instruction format, MSB first:
  - opcode[3], rd[REG_AW], rs[REG_AW], then low field.
  - IMM_W = DATA_W - 3 - 2*REG_AW (default 4). Elaboration must fail if IMM_W < 1.
  - R-type low field = rt[REG_AW] in the top bits; remaining bits ignored.
  - I-type low field = imm[IMM_W], sign-extended.
- Opcodes:
  - 000 ADD: rd = rs + rt.
  - 001 SUB: rd = rs - rt.
  - 010 AND: rd = rs & rt.
  - 011 OR: rd = rs | rt.
  - 100 ADDI: rd = rs + imm.
  - 101 LW: rd = mem[rs + imm].
  - 110 SW: mem[rs + imm] = rd.
  - 111 BEQ: if rd == rs, pc = pc + 1 + imm.
- Width rules:
  - Arithmetic is modulo 2**DATA_W; no flags.
  - Memory address = low ADDR_W bits of rs + imm.
  - PC wraps modulo 2**ADDR_W.
- Register file: r0 always reads 0; writes to r0 are dropped and do not pulse write_flag.
- States:
  - IDLE: go to FETCH when run = 1.
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. On mem_done, IR <= mem_rdata, go to DECODE.
  - DECODE: A <= reg[rs]; B <= reg[rt] for R-type, reg[rd] for SW/BEQ; pc <= pc + 1.
  - EXECUTE:
    - ALU/ADDI: ALUOut computed, go to WB.
    - LW/SW: ALUOut = address, go to MEM.
    - BEQ: if taken, pc <= pc + sext(imm) and pulse beq_taken; retire; then boundary.
  - MEM: mem_req = 1, mem_we = (op == SW), mem_wdata = B. On mem_done:
    - LW: MDR <= mem_rdata, go to WB.
    - SW: retire, boundary.
  - WB: reg[rd] <= ALUOut (or MDR for LW); pulse write_flag unless rd = 0; retire; boundary.
  - Boundary: next state is FETCH if run = 1, else IDLE.
- Zero-wait latency (mem_done in the first request cycle): ALU/ADDI 4 cycles, LW 5, SW 4, BEQ 3. Each wait cycle adds 1.
- run = 0 mid-instruction: the instruction still completes; the FSM halts only at the boundary.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_BEQ;
  - state enum IDLE/FETCH/DECODE/EXECUTE/MEM/WB;
  - IMM_W derivation function;
  - field-extract helpers.
- One sub-module, cpu_reg_file:
  - parameters DATA_W and REG_AW;
  - two combinational read ports plus the debug read port;
  - one synchronous write port with the r0 guard;
  - synchronous reset to 0.

Test Plan:
- Reset, run = 1, memory returns 0x1085 (ADDI r1,r0,5) at pc 0 with zero-wait -> write_flag pulses in cycle 4, dbg r1 = 5, pc = 1, retire pulses once.
- ADDI r2,r0,-1 (imm 1111); ADD r3,r1,r2; SUB r4,r0,r1 -> r2 = 0x1FFF, r3 = 4, r4 = 0x1FFB.
- SW r1,[r0+3] -> MEM cycle shows mem_we = 1, mem_addr = 3, mem_wdata = 5. Then LW r5,[r0+3] with 3 wait cycles -> mem_req high 4 cycles with stable mem_addr = 3, r5 = 5, 8 cycles total.
- At pc = 10, BEQ r1,r1,-2 -> beq_taken pulses, pc = 9. At pc = 11, BEQ r1,r0,+3 -> no pulse, pc = 12.
- ADDI r0,r0,7 -> dbg r0 = 0, write_flag stays 0, retire pulses.
- Reset during FETCH wait -> next cycle mem_req = 0, pc = RESET_PC, all regs 0. Drop run during EXECUTE of ADD -> WB completes, FSM goes to IDLE, busy = 0.
